// File: rtl/chunked_serial_adder_if.sv
//------------------------------------------------------------------------------
// Module      : chunked_serial_adder_if
// Description : Operand/result handshake bundle for chunked_serial_adder.
//               Optional macro CHUNKED_ADDER_SUB_EN adds the 'sub' signal.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

`ifdef CHUNKED_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/chunked_serial_adder.sv
//------------------------------------------------------------------------------
// Module      : chunked_serial_adder
// Description : Multi-cycle WIDTH-bit adder that processes CHUNK bits per
//               clock, rippling the carry through a register between chunks.
//               Valid/ready handshake on operands and result.
//               Optional macro CHUNKED_ADDER_SUB_EN enables a - b - cin mode.
//               WIDTH must be an integer multiple of CHUNK.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  chunked_serial_adder_if.slave   bus
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             sub_q, sub_d;
  logic             sub_in;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   chunk_res;
  logic [CHUNK-1:0] s_w;
  logic             c_w;
  logic             ovf_w;

`ifdef CHUNKED_ADDER_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Select the operand slices addressed by the current chunk index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Subtraction reuses the adder: B inverted here, initial carry inverted at capture.
  assign b_eff     = b_sl ^ {CHUNK{sub_q}};
  assign chunk_res = {1'b0, a_sl} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
  assign s_w       = chunk_res[CHUNK-1:0];
  assign c_w       = chunk_res[CHUNK];
  // Carry into the MSB is a^b^s at that bit; overflow when it differs from carry out.
  assign ovf_w     = a_sl[CHUNK-1] ^ b_eff[CHUNK-1] ^ s_w[CHUNK-1] ^ c_w;

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    sub_d       = sub_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = sub_in;
          carry_d = bus.cin ^ sub_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NCH; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = s_w;
          end
        end
        carry_d = c_w;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d      = c_w;
          ovf_d       = ovf_w;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      sub_q       <= sub_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
//------------------------------------------------------------------------------
// Module      : tb_chunked_serial_adder
// Description : Self-checking bench for chunked_serial_adder (32/8 and 16/16).
//               Honours CHUNKED_ADDER_SUB_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_chunked_serial_adder;

  localparam int W   = 32;
  localparam int CH  = 8;
  localparam int NCH = W / CH;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  chunked_serial_adder_if #(.WIDTH(W))  bus   ();
  chunked_serial_adder_if #(.WIDTH(16)) bus16 ();

  chunked_serial_adder #(.WIDTH(W), .CHUNK(CH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    longint ua, ub, sa, sb, u, s;
    logic   c, o;
    ua = longint'(a);
    ub = longint'(b);
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      u = ua - ub - longint'(cin);
      s = sa - sb - longint'(cin);
      c = (u >= 0);
    end else begin
      u = ua + ub + longint'(cin);
      s = sa + sb + longint'(cin);
      c = (u >= 64'sh1_0000_0000);
    end
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {o, c, u[W-1:0]};
  endfunction

  // Present one operand set, wait for the result; lat=-1 on timeout.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output int lat, output int busy_cycles);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub      = sub;
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    busy_cycles  = bus.busy ? 1 : 0;
    lat          = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cycles++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.sum !== 32'h0) $display("FAIL reset_sum: got %h want %h", bus.sum, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b00) $display("FAIL reset_cout_ovf: got %b want 00", {bus.cout, bus.ovf}); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int lat, bc;
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, bc);
    total_cnt++; if (lat !== NCH) $display("FAIL wrap_latency: got %0d want %0d", lat, NCH); else pass_cnt++;
    total_cnt++; if (bc !== NCH) $display("FAIL wrap_busy_cycles: got %0d want %0d", bc, NCH); else pass_cnt++;
    total_cnt++; if (bus.sum !== 32'h0) $display("FAIL wrap_sum: got %h want %h", bus.sum, 32'h0); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b10) $display("FAIL wrap_cout_ovf: got %b want 10", {bus.cout, bus.ovf}); else pass_cnt++;
    release_out();
  endtask

  task automatic test_signed_ovf();
    int lat, bc;
    start_op(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, lat, bc);
    total_cnt++; if (bus.sum !== 32'h8000_0000) $display("FAIL povf_sum: got %h want %h", bus.sum, 32'h8000_0000); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b01) $display("FAIL povf_cout_ovf: got %b want 01", {bus.cout, bus.ovf}); else pass_cnt++;
    release_out();
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat, bc);
    total_cnt++; if (bus.sum !== 32'h0) $display("FAIL novf_sum: got %h want %h", bus.sum, 32'h0); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b11) $display("FAIL novf_cout_ovf: got %b want 11", {bus.cout, bus.ovf}); else pass_cnt++;
    release_out();
  endtask

  task automatic test_backpressure();
    int lat, bc;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat, bc);
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (bus.sum !== 32'h2345_6789) $display("FAIL bp_sum_hold[%0d]: got %h want %h", i, bus.sum, 32'h2345_6789); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); else pass_cnt++;
      bus.in_valid = (i == 2);
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h0BAD_F00D;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL bp_no_capture_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.sum !== 32'h2345_6789) $display("FAIL bp_sum_after: got %h want %h", bus.sum, 32'h2345_6789); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc;
    bus.in_valid = 1'b1;
    bus.a        = 32'hAAAA_AAAA;
    bus.b        = 32'h5555_5555;
    bus.cin      = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub      = 1'b0;
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.sum !== 32'h0) $display("FAIL rst_run_sum: got %h want %h", bus.sum, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_run_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_run_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_run_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(32'd5, 32'd3, 1'b1, 1'b0, lat, bc);
    total_cnt++; if (bus.sum !== 32'd9) $display("FAIL rst_after_sum: got %h want %h", bus.sum, 32'd9); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b00) $display("FAIL rst_after_cout_ovf: got %b want 00", {bus.cout, bus.ovf}); else pass_cnt++;
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat, bc, n;
    start_op(32'd1, 32'd2, 1'b0, 1'b0, lat, bc);
    total_cnt++; if (bus.sum !== 32'd3) $display("FAIL b2b_first_sum: got %h want %h", bus.sum, 32'd3); else pass_cnt++;
    bus.in_valid  = 1'b1;
    bus.a         = 32'd100;
    bus.b         = 32'd200;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL b2b_no_bypass_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_idle_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b want 1", bus.busy); else pass_cnt++;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    total_cnt++; if (n !== NCH) $display("FAIL b2b_latency: got %0d want %0d", n, NCH); else pass_cnt++;
    total_cnt++; if (bus.sum !== 32'd300) $display("FAIL b2b_second_sum: got %h want %h", bus.sum, 32'd300); else pass_cnt++;
    release_out();
  endtask

  task automatic test_random();
    int lat, bc;
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W+1:0] exp;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = (i % 4 == 0) ? ~a : W'($urandom);
      cin = 1'($urandom_range(0, 1));
`ifdef CHUNKED_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      exp = model(a, b, cin, sub);
      start_op(a, b, cin, sub, lat, bc);
      total_cnt++; if (lat !== NCH) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, NCH); else pass_cnt++;
      total_cnt++; if ({bus.ovf, bus.cout, bus.sum} !== exp)
        $display("FAIL rand_result[%0d] a=%h b=%h cin=%b sub=%b: got ovf/cout/sum %b/%b/%h want %b/%b/%h",
                 i, a, b, cin, sub, bus.ovf, bus.cout, bus.sum, exp[W+1], exp[W], exp[W-1:0]);
      else pass_cnt++;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      release_out();
    end
  endtask

`ifdef CHUNKED_ADDER_SUB_EN
  task automatic test_sub();
    int lat, bc;
    start_op(32'd5, 32'd7, 1'b0, 1'b1, lat, bc);
    total_cnt++; if (bus.sum !== 32'hFFFF_FFFE) $display("FAIL sub_borrow_sum: got %h want %h", bus.sum, 32'hFFFF_FFFE); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b00) $display("FAIL sub_borrow_cout_ovf: got %b want 00", {bus.cout, bus.ovf}); else pass_cnt++;
    release_out();
    start_op(32'd7, 32'd5, 1'b1, 1'b1, lat, bc);
    total_cnt++; if (bus.sum !== 32'd1) $display("FAIL sub_noborrow_sum: got %h want %h", bus.sum, 32'd1); else pass_cnt++;
    total_cnt++; if ({bus.cout, bus.ovf} !== 2'b10) $display("FAIL sub_noborrow_cout_ovf: got %b want 10", {bus.cout, bus.ovf}); else pass_cnt++;
    release_out();
  endtask
`endif

  task automatic test_single_chunk();
    bus16.in_valid = 1'b1;
    bus16.a        = 16'hFFFF;
    bus16.b        = 16'hFFFF;
    bus16.cin      = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    total_cnt++; if (bus16.out_valid !== 1'b0) $display("FAIL w16_valid_early: got %b want 0", bus16.out_valid); else pass_cnt++;
    total_cnt++; if (bus16.busy !== 1'b1) $display("FAIL w16_busy: got %b want 1", bus16.busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus16.out_valid !== 1'b1) $display("FAIL w16_valid: got %b want 1", bus16.out_valid); else pass_cnt++;
    total_cnt++; if (bus16.sum !== 16'hFFFF) $display("FAIL w16_sum: got %h want %h", bus16.sum, 16'hFFFF); else pass_cnt++;
    total_cnt++; if ({bus16.cout, bus16.ovf} !== 2'b10) $display("FAIL w16_cout_ovf: got %b want 10", {bus16.cout, bus16.ovf}); else pass_cnt++;
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    total_cnt++; if (bus16.out_valid !== 1'b0) $display("FAIL w16_release: got %b want 0", bus16.out_valid); else pass_cnt++;
  endtask

  initial begin
    clk             = 1'b0;
    rst_n           = 1'b0;
    pass_cnt        = 0;
    total_cnt       = 0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.cin         = 1'b0;
    bus.out_ready   = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.cin       = 1'b0;
    bus16.out_ready = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
    bus.sub         = 1'b0;
    bus16.sub       = 1'b0;
`endif

    test_reset();
    test_wrap();
    test_signed_ovf();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_single_chunk();
`ifdef CHUNKED_ADDER_SUB_EN
    test_sub();
`endif
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, rippling the carry through a register between chunks.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths.
- Trades latency for area: one CHUNK-bit adder is reused WIDTH/CHUNK times.

Parameters:
WIDTH, 32, operand and result width in bits
CHUNK, 8, bits added per clock; WIDTH must be an integer multiple of CHUNK; CHUNK=WIDTH gives a single-cycle compute

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result held and valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, registered
cout  output  1  carry-out of MSB, registered
ovf  output  1  signed overflow, registered
busy  output  1  high in RUN state

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, immediate):
  - state=IDLE.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0.
  - Internal operand, carry and chunk-index registers cleared.
  - in_ready=1 (decoded from state).
- Let NCH = WIDTH/CHUNK; chunk index idx is clog2(NCH) bits, minimum 1.
- State machine:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: latch a, b, cin (cin into carry register); idx=0; go to RUN.
  - RUN:
    - in_ready=0, busy=1.
    - Each cycle: compute {c, s} = a[idx*CHUNK +: CHUNK] + b[same slice] + carry.
    - Write s into sum[idx*CHUNK +: CHUNK]; carry <= c; idx <= idx+1.
    - On the cycle idx==NCH-1:
      - cout <= c.
      - ovf <= carry-into-MSB XOR c, derived from the last chunk: (a_msb ^ b_msb ^ s_msb) ^ c.
      - out_valid <= 1; go to DONE.
  - DONE:
    - out_valid=1.
    - sum, cout and ovf held stable while out_ready=0.
    - On out_ready=1: out_valid <= 0; go to IDLE.
    - sum, cout and ovf keep their last value after the handshake; they are not cleared.
- Latency: operands accepted at edge k give out_valid=1 after edge k+NCH. With out_ready held high, throughput is one result per NCH+2 cycles.
- in_valid while not in IDLE: ignored, no capture. Operands may change freely after acceptance.
- No bypass: out_ready and in_valid high together in DONE does not accept a new operand that cycle; it is accepted in IDLE on the following cycle.
- Wrap-around: the result is modulo 2^WIDTH, and cout carries bit WIDTH.
- The sum register is written chunk-by-chunk; consumers read it only while out_valid=1.
- Reset mid-RUN or mid-DONE: the operation is aborted and all registers return to their reset values. No partial result is ever presented with out_valid=1.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: CHUNKED_ADDER_SUB_EN
- Defined:
  - Extra port sub (input, 1), sampled with the operands at acceptance.
  - sub=1 computes a - b - cin: B is inverted per chunk and the initial carry is ~cin.
  - cout=1 means no borrow.
  - ovf is signed overflow of the subtraction, same formula applied to inverted B.
  - sub=0 is identical to add mode.
- Not defined: port sub absent; add only.

Test Plan:
- WIDTH=32, CHUNK=8:
  - Stimulus: a=0xFFFFFFFF, b=0x00000001, cin=0.
  - Required: out_valid rises 4 cycles after acceptance; sum=0x00000000, cout=1, ovf=0; busy high for exactly 4 cycles.
- Signed overflow:
  - Stimulus: a=0x7FFFFFFF, b=0x00000000, cin=1.
  - Required: sum=0x80000000, cout=0, ovf=1.
  - Stimulus: a=0x80000000, b=0x80000000, cin=0.
  - Required: sum=0, cout=1, ovf=1.
- Backpressure:
  - Stimulus: a=0x12345678, b=0x11111111, cin=0; out_ready held low 5 cycles after out_valid.
  - Required: sum=0x23456789 stable throughout; in_ready=0; a second in_valid pulse is not captured.
  - Then out_ready=1: out_valid falls next edge; in_ready=1.
- Reset mid-RUN:
  - Stimulus: rst_n pulled low asynchronously at idx=2.
  - Required: sum=0, out_valid=0, busy=0, in_ready=1 immediately.
  - A following operation 5+3+1 yields 9, with no stale carry.
- CHUNK=WIDTH=16:
  - Stimulus: a=0xFFFF, b=0xFFFF, cin=1.
  - Required: out_valid 1 cycle after acceptance; sum=0xFFFF, cout=1.
- With CHUNKED_ADDER_SUB_EN:
  - Stimulus: sub=1, a=5, b=7, cin=0.
  - Required: sum=0xFFFFFFFE, cout=0 (borrow).
  - Stimulus: sub=1, a=7, b=5, cin=1.
  - Required: sum=1, cout=1.
